// File: rtl/math_chk_pkg.sv
// Shared encodings and the expected-result function for the math result checker.
package math_chk_pkg;

    localparam int OPD_W_DEF = 4;
    localparam int RES_W_DEF = 8;

    // Function select carried on the mode input
    localparam logic [1:0] MODE_ADD2 = 2'b00;
    localparam logic [1:0] MODE_MUL  = 2'b01;
    localparam logic [1:0] MODE_ADD  = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;

    // Checker FSM encodings, visible on state_o
    localparam logic [1:0] ST_PRIME     = 2'd0;
    localparam logic [1:0] ST_CHECK     = 2'd1;
    localparam logic [1:0] ST_DECOUPLED = 2'd2;
    localparam logic [1:0] ST_SETTLE    = 2'd3;

    // Result the reconfigurable partition should produce for the given operands.
    // Operands are zero-extended first so products and sums never truncate.
    function automatic logic [RES_W_DEF-1:0] calc_expected(
        input logic [1:0]           mode,
        input logic [OPD_W_DEF-1:0] a,
        input logic [OPD_W_DEF-1:0] b
    );
        logic [RES_W_DEF-1:0] ax;
        logic [RES_W_DEF-1:0] bx;
        ax = RES_W_DEF'(a);
        bx = RES_W_DEF'(b);
        case (mode)
            MODE_ADD2: calc_expected = (ax << 1) + bx;
            MODE_MUL:  calc_expected = ax * bx;
            MODE_ADD:  calc_expected = ax + bx;
            default:   calc_expected = '0;
        endcase
    endfunction

endpackage

// File: rtl/math_expect_pipe.sv
// Fixed-depth delay line that aligns the expected value with the RP's registered output.
module math_expect_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift the expected value one stage per clock; reset flushes every stage to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/math_result_checker.sv
// In-system checker for the math reconfigurable partition: recomputes the expected
// result, aligns it with rp_out, and tallies passes/failures while masking decouple
// windows and mode switches.
module math_result_checker
    import math_chk_pkg::*;
#(
    parameter int OPD_W         = OPD_W_DEF,
    parameter int RES_W         = RES_W_DEF,
    parameter int LATENCY       = 1,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset_vio,
    input  logic [OPD_W-1:0] in1,
    input  logic [OPD_W-1:0] in2,
    input  logic [RES_W-1:0] rp_out,
    input  logic             rp_decouple,
    input  logic [1:0]       mode,
    input  logic             clear,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err_sticky,
    output logic [RES_W-1:0] first_fail_exp,
    output logic [RES_W-1:0] first_fail_got,
    output logic [1:0]       state_o
);

    localparam int PC_W = 8;
    localparam logic [PC_W-1:0] PRIME_LOAD  = PC_W'(LATENCY + 1);
    localparam logic [PC_W-1:0] SETTLE_LOAD = PC_W'(SETTLE_CYCLES);
    localparam logic [PC_W-1:0] PC_ONE      = PC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [1:0]       state;
    logic [PC_W-1:0]  phase_cnt;
    logic [1:0]       mode_q;
    logic [RES_W-1:0] exp_now;
    logic [RES_W-1:0] exp_dly;
    logic             cmp_en;
    logic             match;

    assign exp_now = calc_expected(mode, in1, in2);

    math_expect_pipe #(
        .WIDTH (RES_W),
        .DEPTH (LATENCY)
    ) u_expect_pipe (
        .clk   (clk),
        .reset (reset_vio),
        .din   (exp_now),
        .dout  (exp_dly)
    );

    // Sequence PRIME -> CHECK, park in DECOUPLED during reconfiguration, and SETTLE after release or a mode switch
    always_ff @(posedge clk) begin
        if (reset_vio) begin
            state     <= ST_PRIME;
            phase_cnt <= PRIME_LOAD;
            mode_q    <= mode;
        end else begin
            mode_q <= mode;
            if (rp_decouple) begin
                state <= ST_DECOUPLED;
            end else if (state == ST_DECOUPLED) begin
                state     <= ST_SETTLE;
                phase_cnt <= SETTLE_LOAD;
            end else if (mode != mode_q) begin
                state     <= ST_SETTLE;
                phase_cnt <= SETTLE_LOAD;
            end else begin
                case (state)
                    ST_PRIME: begin
                        if (phase_cnt <= PC_ONE) begin
                            state <= ST_CHECK;
                        end else begin
                            phase_cnt <= phase_cnt - PC_ONE;
                        end
                    end
                    ST_SETTLE: begin
                        if (phase_cnt <= PC_ONE) begin
                            state     <= ST_PRIME;
                            phase_cnt <= PRIME_LOAD;
                        end else begin
                            phase_cnt <= phase_cnt - PC_ONE;
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

    // rp_out is garbage whenever decouple is high, so a compare is never made in that cycle
    assign cmp_en = (state == ST_CHECK) && !rp_decouple && (mode != MODE_OFF);
    assign match  = (rp_out == exp_dly);

    // Saturating pass/fail tallies and first-failure capture; clear overrides any compare in the same cycle
    always_ff @(posedge clk) begin
        if (reset_vio || clear) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            err_sticky     <= 1'b0;
            first_fail_exp <= '0;
            first_fail_got <= '0;
        end else if (cmp_en) begin
            if (match) begin
                if (pass_cnt != '1) begin
                    pass_cnt <= pass_cnt + CNT_ONE;
                end
            end else begin
                if (fail_cnt != '1) begin
                    fail_cnt <= fail_cnt + CNT_ONE;
                end
                if (!err_sticky) begin
                    err_sticky     <= 1'b1;
                    first_fail_exp <= exp_dly;
                    first_fail_got <= rp_out;
                end
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_math_result_checker.sv
// Self-checking bench for math_result_checker: directed steps with randomized data,
// checked every cycle against a quiet-window reference model.
module tb_math_result_checker;

    localparam int TB_LAT    = 1;
    localparam int TB_SETTLE = 4;
    localparam int TB_CNT_W  = 4;
    localparam int CNT_MAX   = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                reset_vio = 1'b1;
    logic [3:0]          in1 = '0;
    logic [3:0]          in2 = '0;
    logic [7:0]          rp_out = '0;
    logic                rp_decouple = 1'b0;
    logic [1:0]          mode = 2'b00;
    logic                clear = 1'b0;
    logic [TB_CNT_W-1:0] pass_cnt;
    logic [TB_CNT_W-1:0] fail_cnt;
    logic                err_sticky;
    logic [7:0]          first_fail_exp;
    logic [7:0]          first_fail_got;
    logic [1:0]          state_o;

    int checks = 0;
    int errors = 0;

    // Reference model state: quiet cycles left before checking, decouple flag, delayed expectations
    int         quiet = 0;
    bit         dec_st = 1'b0;
    logic [1:0] mode_prev = 2'b00;
    logic [7:0] expq[$];
    int         m_pass = 0;
    int         m_fail = 0;
    bit         m_sticky = 1'b0;
    logic [7:0] m_fexp = '0;
    logic [7:0] m_fgot = '0;

    math_result_checker #(
        .OPD_W         (4),
        .RES_W         (8),
        .LATENCY       (TB_LAT),
        .SETTLE_CYCLES (TB_SETTLE),
        .CNT_W         (TB_CNT_W)
    ) dut (
        .clk            (clk),
        .reset_vio      (reset_vio),
        .in1            (in1),
        .in2            (in2),
        .rp_out         (rp_out),
        .rp_decouple    (rp_decouple),
        .mode           (mode),
        .clear          (clear),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .err_sticky     (err_sticky),
        .first_fail_exp (first_fail_exp),
        .first_fail_got (first_fail_got),
        .state_o        (state_o)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic [7:0] refResult(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b);
        int r;
        case (m)
            2'b00:   r = 2 * int'(a) + int'(b);
            2'b01:   r = int'(a) * int'(b);
            2'b10:   r = int'(a) + int'(b);
            default: r = 0;
        endcase
        return 8'(r);
    endfunction

    task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, and step past the clock edge
    task automatic applyStimulus(input bit r, input bit d, input bit c, input logic [1:0] m,
                                 input logic [3:0] a, input logic [3:0] b, input logic [7:0] corrupt);
        bit do_cmp;
        reset_vio   = r;
        rp_decouple = d;
        clear       = c;
        mode        = m;
        in1         = a;
        in2         = b;
        rp_out      = d ? 8'($urandom) : (expq[0] ^ corrupt);

        do_cmp = !r && !dec_st && (quiet == 0) && !d && (m != 2'b11);
        if (r || c) begin
            m_pass = 0; m_fail = 0; m_sticky = 1'b0; m_fexp = '0; m_fgot = '0;
        end else if (do_cmp) begin
            if (rp_out == expq[0]) begin
                if (m_pass < CNT_MAX) m_pass++;
            end else begin
                if (m_fail < CNT_MAX) m_fail++;
                if (!m_sticky) begin
                    m_sticky = 1'b1; m_fexp = expq[0]; m_fgot = rp_out;
                end
            end
        end

        if (r) begin
            dec_st = 1'b0; quiet = TB_LAT + 1;
        end else if (d) begin
            dec_st = 1'b1;
        end else if (dec_st) begin
            dec_st = 1'b0; quiet = TB_SETTLE + TB_LAT + 1;
        end else if (m != mode_prev) begin
            quiet = TB_SETTLE + TB_LAT + 1;
        end else if (quiet > 0) begin
            quiet--;
        end
        mode_prev = m;

        if (r) begin
            foreach (expq[i]) expq[i] = '0;
        end else begin
            expq.push_back(refResult(m, a, b));
            void'(expq.pop_front());
        end

        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        logic [1:0] exp_state;
        if (dec_st)                    exp_state = 2'd2;
        else if (quiet == 0)           exp_state = 2'd1;
        else if (quiet > TB_LAT + 1)   exp_state = 2'd3;
        else                           exp_state = 2'd0;
        checkVal("pass_cnt",       16'(pass_cnt),       16'(m_pass));
        checkVal("fail_cnt",       16'(fail_cnt),       16'(m_fail));
        checkVal("err_sticky",     16'(err_sticky),     16'(m_sticky));
        checkVal("first_fail_exp", 16'(first_fail_exp), 16'(m_fexp));
        checkVal("first_fail_got", 16'(first_fail_got), 16'(m_fgot));
        checkVal("state_o",        16'(state_o),        16'(exp_state));
    endtask

    task automatic runCycle(input bit r, input bit d, input bit c, input logic [1:0] m,
                            input logic [3:0] a, input logic [3:0] b, input logic [7:0] corrupt);
        applyStimulus(r, d, c, m, a, b, corrupt);
        checkOutput();
    endtask

    initial begin
        bit         rd;
        logic [1:0] rm;
        logic [3:0] ra;
        logic [3:0] rb;
        int         dec_left;

        for (int i = 0; i < TB_LAT; i++) expq.push_back(8'h00);

        $display("[TB] reset");
        runCycle(1, 0, 0, 2'b00, 4'd3, 4'd5, 8'h00);
        runCycle(1, 0, 0, 2'b00, 4'd3, 4'd5, 8'h00);
        checkVal("reset_state", 16'(state_o), 16'd0);
        checkVal("reset_pass",  16'(pass_cnt), 16'd0);

        $display("[TB] alignment and pass counting");
        runCycle(0, 0, 0, 2'b00, 4'd3, 4'd5, 8'h00);
        runCycle(0, 0, 0, 2'b00, 4'd3, 4'd5, 8'h00);
        checkVal("prime_to_check", 16'(state_o), 16'd1);
        for (int i = 0; i < 10; i++) runCycle(0, 0, 0, 2'b00, 4'd3, 4'd5, 8'h00);
        checkVal("align_pass10", 16'(pass_cnt), 16'd10);
        checkVal("align_fail0",  16'(fail_cnt), 16'd0);

        $display("[TB] first-failure capture");
        runCycle(0, 0, 0, 2'b00, 4'd3, 4'd5, 8'h07);
        runCycle(0, 0, 0, 2'b00, 4'd3, 4'd5, 8'h06);
        checkVal("ff_fail2",  16'(fail_cnt),       16'd2);
        checkVal("ff_sticky", 16'(err_sticky),     16'd1);
        checkVal("ff_exp",    16'(first_fail_exp), 16'h0B);
        checkVal("ff_got",    16'(first_fail_got), 16'h0C);

        $display("[TB] decouple handling");
        runCycle(0, 0, 1, 2'b00, 4'd3, 4'd5, 8'h00);
        for (int i = 0; i < 10; i++) runCycle(0, 1, 0, 2'b00, 4'd3, 4'd5, 8'h00);
        checkVal("dec_state", 16'(state_o), 16'd2);
        checkVal("dec_pass0", 16'(pass_cnt), 16'd0);
        for (int i = 0; i < 7; i++) runCycle(0, 0, 0, 2'b00, 4'd3, 4'd5, 8'h00);
        checkVal("settle_pass0", 16'(pass_cnt), 16'd0);
        runCycle(0, 0, 0, 2'b00, 4'd3, 4'd5, 8'h00);
        checkVal("resume_pass1", 16'(pass_cnt), 16'd1);

        $display("[TB] mode change");
        runCycle(0, 0, 1, 2'b00, 4'd3, 4'd5, 8'h00);
        for (int i = 0; i < 12; i++) runCycle(0, 0, 0, 2'b01, 4'd15, 4'd15, 8'h00);
        checkVal("mode_pass6", 16'(pass_cnt), 16'd6);
        checkVal("mode_fail0", 16'(fail_cnt), 16'd0);

        $display("[TB] saturation");
        runCycle(0, 0, 1, 2'b01, 4'd15, 4'd15, 8'h00);
        for (int i = 0; i < 20; i++) runCycle(0, 0, 0, 2'b01, 4'd15, 4'd15, 8'h00);
        checkVal("sat_pass15", 16'(pass_cnt), 16'd15);
        checkVal("sat_fail0",  16'(fail_cnt), 16'd0);

        $display("[TB] clear collides with mismatch");
        runCycle(0, 0, 1, 2'b01, 4'd15, 4'd15, 8'h5A);
        checkVal("clr_fail0",   16'(fail_cnt),   16'd0);
        checkVal("clr_sticky0", 16'(err_sticky), 16'd0);
        checkVal("clr_state",   16'(state_o),    16'd1);

        $display("[TB] randomized traffic");
        rm = 2'b00; dec_left = 0;
        for (int i = 0; i < 400; i++) begin
            ra = 4'($urandom); rb = 4'($urandom);
            if ($urandom_range(0, 29) == 0) rm = 2'($urandom);
            if (dec_left == 0 && $urandom_range(0, 59) == 0) dec_left = $urandom_range(1, 8);
            rd = (dec_left > 0);
            if (dec_left > 0) dec_left--;
            runCycle(0, rd, $urandom_range(0, 39) == 0, rm, ra, rb,
                     ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
        end

        $display("[TB] reset during SETTLE and DECOUPLED");
        runCycle(0, 0, 0, 2'b00, 4'd1, 4'd2, 8'h00);
        runCycle(0, 0, 0, 2'b10, 4'd1, 4'd2, 8'h00);
        runCycle(0, 0, 0, 2'b10, 4'd1, 4'd2, 8'h00);
        checkVal("pre_reset_settle", 16'(state_o), 16'd3);
        runCycle(1, 0, 0, 2'b10, 4'd1, 4'd2, 8'h00);
        checkVal("rst_state",  16'(state_o),        16'd0);
        checkVal("rst_pass",   16'(pass_cnt),       16'd0);
        checkVal("rst_fail",   16'(fail_cnt),       16'd0);
        checkVal("rst_sticky", 16'(err_sticky),     16'd0);
        checkVal("rst_fexp",   16'(first_fail_exp), 16'd0);
        checkVal("rst_fgot",   16'(first_fail_got), 16'd0);
        runCycle(0, 1, 0, 2'b10, 4'd1, 4'd2, 8'h00);
        runCycle(1, 1, 0, 2'b10, 4'd1, 4'd2, 8'h00);
        checkVal("rst_in_dec", 16'(state_o), 16'd0);
        runCycle(0, 1, 0, 2'b10, 4'd1, 4'd2, 8'h00);
        checkVal("redecouple", 16'(state_o), 16'd2);
        for (int i = 0; i < 12; i++) runCycle(0, 0, 0, 2'b10, 4'd7, 4'd9, 8'h00);
        checkVal("final_pass", 16'(pass_cnt), 16'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
